// File: rtl/bus_arbiter.sv
// Two-master shared-bus arbiter: round-robin tie break, bounded bursts,
// direct handoff between masters and a combinational bus mux from the grant.
module bus_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0Req,
    input  logic        m1Req,
    input  logic        m0We,
    input  logic        m1We,
    input  logic [31:0] m0Addr,
    input  logic [31:0] m1Addr,
    input  logic [31:0] m0WData,
    input  logic [31:0] m1WData,
    output logic        m0Gnt,
    output logic        m1Gnt,
    output logic [31:0] m0RData,
    output logic [31:0] m1RData,
    output logic        m0RValid,
    output logic        m1RValid,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [31:0] busWData,
    input  logic [31:0] busRData,
    output logic [1:0]  busOwner
);

    localparam int unsigned CNT_W = 8;

    // State encoding doubles as the busOwner code
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] GNT_M0 = 2'b01;
    localparam logic [1:0] GNT_M1 = 2'b10;

    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] burst_cnt_next;
    logic             last_owner;       // 0: master 0 held the bus last, 1: master 1
    logic             last_owner_next;
    logic             transfer;

    // State, burst counter and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            last_owner <= 1'b1;
        end else begin
            state      <= state_next;
            burst_cnt  <= burst_cnt_next;
            last_owner <= last_owner_next;
        end
    end

    // Arbitration decisions and bus mux driven from the registered grant
    always_comb begin
        state_next      = state;
        burst_cnt_next  = burst_cnt;
        last_owner_next = last_owner;
        transfer        = 1'b0;
        m0Gnt           = 1'b0;
        m1Gnt           = 1'b0;
        m0RData         = 32'h0;
        m1RData         = 32'h0;
        m0RValid        = 1'b0;
        m1RValid        = 1'b0;
        busWe           = 1'b0;
        busAddr         = 32'h0;
        busWData        = 32'h0;
        busOwner        = state;

        case (state)
            IDLE: begin
                if (m0Req && m1Req) begin
                    state_next = last_owner ? GNT_M0 : GNT_M1;
                end else if (m0Req) begin
                    state_next = GNT_M0;
                end else if (m1Req) begin
                    state_next = GNT_M1;
                end
            end
            GNT_M0: begin
                m0Gnt    = 1'b1;
                m0RData  = busRData;
                transfer = m0Req;
                if (m0Req) begin
                    busWe    = m0We;
                    busAddr  = m0Addr;
                    busWData = m0WData;
                    m0RValid = ~m0We;
                end
                if (!m0Req) begin
                    state_next = m1Req ? GNT_M1 : IDLE;
                end else if (m1Req && (burst_cnt == BURST_LAST)) begin
                    state_next = GNT_M1;
                end
            end
            GNT_M1: begin
                m1Gnt    = 1'b1;
                m1RData  = busRData;
                transfer = m1Req;
                if (m1Req) begin
                    busWe    = m1We;
                    busAddr  = m1Addr;
                    busWData = m1WData;
                    m1RValid = ~m1We;
                end
                if (!m1Req) begin
                    state_next = m0Req ? GNT_M0 : IDLE;
                end else if (m0Req && (burst_cnt == BURST_LAST)) begin
                    state_next = GNT_M0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Counter restarts on any grant change, otherwise counts transfers up to the cap
        if (state_next != state) begin
            burst_cnt_next = '0;
        end else if (transfer && (burst_cnt != BURST_LAST)) begin
            burst_cnt_next = burst_cnt + CNT_W'(1);
        end

        if (state_next == GNT_M0) begin
            last_owner_next = 1'b0;
        end else if (state_next == GNT_M1) begin
            last_owner_next = 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (MAX_BURST 4 and 1) share stimulus and
// are checked every cycle against a behavioural ownership model.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;

    logic [1:0]        gnt0, gnt1, rvalid0, rvalid1, bwe;
    logic [1:0][1:0]   owner;
    logic [1:0][31:0]  baddr, bwdata, brdata, rdata0, rdata1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model: owner 0 idle, 1 master 0, 2 master 1; run = transfers in current grant
    int m_owner [2];
    int m_run   [2];
    int m_last  [2];
    int nx;
    bit mine, other;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h40) return 32'h1234_5678;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int limit_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    assign brdata[0] = mem_rd(baddr[0]);
    assign brdata[1] = mem_rd(baddr[1]);

    bus_arbiter #(.MAX_BURST(4)) dut_a (
        .clk(clk), .reset(reset),
        .m0Req(m0_req), .m1Req(m1_req), .m0We(m0_we), .m1We(m1_we),
        .m0Addr(m0_addr), .m1Addr(m1_addr), .m0WData(m0_wdata), .m1WData(m1_wdata),
        .m0Gnt(gnt0[0]), .m1Gnt(gnt1[0]), .m0RData(rdata0[0]), .m1RData(rdata1[0]),
        .m0RValid(rvalid0[0]), .m1RValid(rvalid1[0]), .busWe(bwe[0]),
        .busAddr(baddr[0]), .busWData(bwdata[0]), .busRData(brdata[0]), .busOwner(owner[0])
    );

    bus_arbiter #(.MAX_BURST(1)) dut_b (
        .clk(clk), .reset(reset),
        .m0Req(m0_req), .m1Req(m1_req), .m0We(m0_we), .m1We(m1_we),
        .m0Addr(m0_addr), .m1Addr(m1_addr), .m0WData(m0_wdata), .m1WData(m1_wdata),
        .m0Gnt(gnt0[1]), .m1Gnt(gnt1[1]), .m0RData(rdata0[1]), .m1RData(rdata1[1]),
        .m0RValid(rvalid0[1]), .m1RValid(rvalid1[1]), .busWe(bwe[1]),
        .busAddr(baddr[1]), .busWData(bwdata[1]), .busRData(brdata[1]), .busOwner(owner[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ownership model advanced from inputs seen at each rising edge
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_owner[k] = 0;
                m_run[k]   = 0;
                m_last[k]  = 2;
            end else begin
                if (m_owner[k] == 0) begin
                    if (m0_req && m1_req) nx = (m_last[k] == 2) ? 1 : 2;
                    else if (m0_req)      nx = 1;
                    else if (m1_req)      nx = 2;
                    else                  nx = 0;
                end else begin
                    mine  = (m_owner[k] == 1) ? m0_req : m1_req;
                    other = (m_owner[k] == 1) ? m1_req : m0_req;
                    if (!mine)
                        nx = other ? 3 - m_owner[k] : 0;
                    else if (other && m_run[k] + 1 >= limit_of(k))
                        nx = 3 - m_owner[k];
                    else
                        nx = m_owner[k];
                end
                if (nx != m_owner[k])
                    m_run[k] = 0;
                else if (nx != 0 && mine && m_run[k] < limit_of(k) - 1)
                    m_run[k] = m_run[k] + 1;
                if (nx != 0) m_last[k] = nx;
                m_owner[k] = nx;
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                automatic int          o  = m_owner[k];
                automatic logic        we_e = 1'b0;
                automatic logic [31:0] ad_e = 32'h0;
                automatic logic [31:0] wd_e = 32'h0;
                automatic logic [31:0] rd_e;
                automatic string       p  = (k == 0) ? "A." : "B.";
                if (o == 1 && m0_req) begin
                    we_e = m0_we; ad_e = m0_addr; wd_e = m0_wdata;
                end
                if (o == 2 && m1_req) begin
                    we_e = m1_we; ad_e = m1_addr; wd_e = m1_wdata;
                end
                rd_e = mem_rd(ad_e);
                chk({p, "m0Gnt"},    32'(gnt0[k]),  32'(o == 1));
                chk({p, "m1Gnt"},    32'(gnt1[k]),  32'(o == 2));
                chk({p, "oneHot"},   32'(gnt0[k] & gnt1[k]), 32'h0);
                chk({p, "busOwner"}, 32'(owner[k]), 32'(o));
                chk({p, "busWe"},    32'(bwe[k]),   32'(we_e));
                chk({p, "busAddr"},  baddr[k],      ad_e);
                chk({p, "busWData"}, bwdata[k],     wd_e);
                chk({p, "m0RData"},  rdata0[k],     (o == 1) ? rd_e : 32'h0);
                chk({p, "m1RData"},  rdata1[k],     (o == 2) ? rd_e : 32'h0);
                chk({p, "m0RValid"}, 32'(rvalid0[k]), 32'(o == 1 && m0_req && !m0_we));
                chk({p, "m1RValid"}, 32'(rvalid1[k]), 32'(o == 2 && m1_req && !m1_we));
            end
        end
    end

    initial begin
        reset = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b1; m1_we = 1'b0;
        m0_addr = 32'h1111_0000; m1_addr = 32'h2222_0000;
        m0_wdata = 32'hAAAA_5555; m1_wdata = 32'h5555_AAAA;
        step();
        step();
        chk_en = 1'b1;

        // Reset state with both requests held
        @(negedge clk);
        chk("rst.m0Gnt",    32'(gnt0[0]), 32'h0);
        chk("rst.m1Gnt",    32'(gnt1[0]), 32'h0);
        chk("rst.busOwner", 32'(owner[0]), 32'h0);
        chk("rst.busWe",    32'(bwe[0]), 32'h0);
        chk("rst.busAddr",  baddr[0], 32'h0);
        chk("rst.busWData", bwdata[0], 32'h0);
        chk("rst.m1RValid", 32'(rvalid1[0]), 32'h0);
        chk("rst.m0RData",  rdata0[0], 32'h0);

        // First tie after reset goes to master 0, next tie from IDLE to master 1
        reset = 1'b0;
        step();
        @(negedge clk);
        chk("tie1.m0Gnt", 32'(gnt0[0]), 32'h1);
        chk("tie1.m1Gnt", 32'(gnt1[0]), 32'h0);
        m0_req = 1'b0; m1_req = 1'b0;
        step();
        m0_req = 1'b1; m1_req = 1'b1;
        step();
        @(negedge clk);
        chk("tie2.m1Gnt", 32'(gnt1[0]), 32'h1);
        chk("tie2.m0Gnt", 32'(gnt0[0]), 32'h0);

        // Single master 0 write
        m0_req = 1'b0; m1_req = 1'b0;
        step();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h100; m0_wdata = 32'hDEAD_BEEF;
        step();
        @(negedge clk);
        chk("wr.m0Gnt",    32'(gnt0[0]), 32'h1);
        chk("wr.busWe",    32'(bwe[0]), 32'h1);
        chk("wr.busAddr",  baddr[0], 32'h100);
        chk("wr.busWData", bwdata[0], 32'hDEAD_BEEF);

        // Master 0 alone holds the bus for 10 cycles, then master 1 arrives
        for (int i = 2; i <= 10; i++) begin
            step();
            @(negedge clk);
            chk("hold.m0Gnt", 32'(gnt0[0]), 32'h1);
        end
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8;
        step();
        @(negedge clk);
        chk("late.m1Gnt", 32'(gnt1[0]), 32'h1);
        chk("late.m0Gnt", 32'(gnt0[0]), 32'h0);

        // Continuous contention: 4/4 bursts on A, alternation on B
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            chk("burst4.m1Gnt", 32'(gnt1[0]), 32'(((i / 4) % 2) == 0));
            chk("burst4.m0Gnt", 32'(gnt0[0]), 32'(((i / 4) % 2) == 1));
            chk("burst1.m1Gnt", 32'(gnt1[1]), 32'((i % 2) == 0));
            step();
        end

        // Master 1 read
        m0_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h40;
        step();
        step();
        @(negedge clk);
        chk("rd.m1RData",  rdata1[0], 32'h1234_5678);
        chk("rd.m1RValid", 32'(rvalid1[0]), 32'h1);
        chk("rd.m0RData",  rdata0[0], 32'h0);
        chk("rd.m0RValid", 32'(rvalid0[0]), 32'h0);

        // Reset during second cycle of a master 1 burst
        m1_req = 1'b0;
        step();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h80; m1_wdata = 32'h0BAD_F00D;
        step();
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("rstmid.m1Gnt",    32'(gnt1[0]), 32'h0);
        chk("rstmid.busOwner", 32'(owner[0]), 32'h0);
        chk("rstmid.busWe",    32'(bwe[0]), 32'h0);
        reset = 1'b0;
        step();
        @(negedge clk);
        chk("rearb.m1Gnt", 32'(gnt1[0]), 32'h1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) m0_req = ~m0_req;
            if ($urandom_range(0, 3) == 0) m1_req = ~m1_req;
            m0_we    = 1'($urandom);
            m1_we    = 1'($urandom);
            m0_addr  = ($urandom_range(0, 7) == 0) ? 32'h40 : $urandom;
            m1_addr  = ($urandom_range(0, 7) == 0) ? 32'h40 : $urandom;
            m0_wdata = $urandom;
            m1_wdata = $urandom;
            reset    = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        step();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
